fifo_level: RTL and testbench
=============================

FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 Parameter B, default 8, bits per data word.
REQ-002 Parameter W, default 4, address bits; depth D = 2**W words.
REQ-003 Parameter AF_LVL, default 2**W-2, almost-full threshold in words (1..D).
REQ-004 Parameter AE_LVL, default 2, almost-empty threshold in words (0..D-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wr  input  1  write request; w_data accepted on the same edge if accepted per REQ-016.
REQ-008 rd  input  1  read request; pops the head word if accepted per REQ-017.
REQ-009 w_data  input  B  write data.
REQ-010 flush  input  1  synchronous empty command.
REQ-011 clr_err  input  1  clears the sticky error flags.
REQ-012 r_data  output  B  head word, show-ahead (valid while empty=0).
REQ-013 full, empty  output  1 each  occupancy = D / occupancy = 0.
REQ-014 almost_full, almost_empty  output  1 each  level >= AF_LVL / level <= AE_LVL.
REQ-015 level  output  W+1  current occupancy, 0..D; overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 A write SHALL be accepted when wr=1 and (full=0, or rd=1 with full=1).
REQ-017 A read SHALL be accepted when rd=1 and empty=0; with empty=1, rd=1 and wr=1, only the write SHALL occur.
REQ-018 The accepted write SHALL store w_data at the write pointer; the pointer advances by 1 modulo D.
REQ-019 The accepted read SHALL advance the read pointer by 1 modulo D; the next head appears on r_data the cycle after the edge.
REQ-020 r_data SHALL be combinational from the storage at the read pointer; its value while empty=1 is don't-care.
REQ-021 level SHALL be a registered counter: +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds D or drops below 0.
REQ-022 full, empty, almost_full and almost_empty SHALL be decoded from the registered level; a write-to-flag latency of 1 cycle applies.
REQ-023 Simultaneous accepted read and write at full SHALL keep full=1 and level=D; the written word becomes the new tail.
REQ-024 overflow SHALL set on the cycle after wr=1 is rejected; underflow SHALL set on the cycle after rd=1 with empty=1 and wr=0.
REQ-025 Both error flags SHALL hold until clr_err=1 or reset; a set event coinciding with clr_err SHALL win (flag stays 1).
REQ-026 flush=1 SHALL zero both pointers and level on the next edge and override rd/wr in that cycle; error flags and storage are unaffected.
REQ-027 Pointer wrap from D-1 to 0 SHALL NOT disturb level or the flags.

Reset
REQ-028 reset=1 SHALL on the next edge set pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0 (AF_LVL>0), overflow=0, underflow=0.
REQ-029 Reset SHALL take priority over flush, rd, wr and clr_err; storage contents are not reset.
REQ-030 Reset asserted mid-burst SHALL discard all queued words; the first post-reset write becomes the head.

Structure
REQ-031 Default widths and threshold defaults SHALL be shared constants in fifo_pkg, reused by the other FIFO variants.
REQ-032 Storage SHALL be a sub-module fifo_regfile (sync write, async read, parameters B, W); control, counter and flags live in fifo_level.

Verification
REQ-033 Reset, write 0x11,0x22,0x33 -> level=3, r_data=0x11, empty=0; 3 reads return 0x11,0x22,0x33, then empty=1.
REQ-034 W=4: write 16 words -> full=1, level=16; 17th wr -> word dropped, overflow=1 one cycle later; clr_err -> overflow=0.
REQ-035 At full, rd=wr=1 with 0xAA -> level stays 16, head advances; 0xAA read 16th.
REQ-036 At empty, rd=wr=1 with 0x5C -> level=1, underflow=0, r_data=0x5C next cycle; rd alone at empty -> underflow=1.
REQ-037 Cycle 40 words in/out past wrap with level 2..14 -> data order preserved; almost_full toggles at 14, almost_empty at 2.
REQ-038 Level 7, flush=1 with wr=1 -> level=0, empty=1, write ignored; reset asserted during burst -> all outputs per REQ-028.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default widths and threshold defaults used by all FIFO variants.
package fifo_pkg;

  localparam int FIFO_B      = 8;
  localparam int FIFO_W      = 4;
  localparam int FIFO_AE_LVL = 2;

  // Almost-full defaults to two words short of the depth.
  function automatic int af_lvl_default(input int w);
    return (2 ** w) - 2;
  endfunction

  localparam int FIFO_AF_LVL = af_lvl_default(FIFO_W);

endpackage

// File: rtl/fifo_level_if.sv
// Bus between a FIFO user (master) and the fifo_level storage/control (slave).
// Handshake: a write is taken on a rising edge when wr=1 and (full=0 or rd=1);
// a read is taken when rd=1 and empty=0; r_data shows the head while empty=0.
interface fifo_level_if #(
  parameter int B = fifo_pkg::FIFO_B,
  parameter int W = fifo_pkg::FIFO_W
) ();

  logic         wr;
  logic         rd;
  logic [B-1:0] w_data;
  logic         flush;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   level;
  logic         overflow;
  logic         underflow;

  modport master (
    output wr, rd, w_data, flush, clr_err,
    input  r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr, rd, w_data, flush, clr_err,
    output r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_regfile.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_regfile #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  logic [B-1:0] mem [2**W];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO with a registered occupancy counter, threshold flags and
// sticky overflow/underflow error flags.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int B      = FIFO_B,
  parameter int W      = FIFO_W,
  parameter int AF_LVL = af_lvl_default(W),
  parameter int AE_LVL = FIFO_AE_LVL
) (
  input  logic         clk,
  input  logic         reset,
  fifo_level_if.slave  bus
);

  localparam logic [W:0] DEPTH = (W+1)'(2 ** W);
  localparam logic [W:0] AF_L  = (W+1)'(AF_LVL);
  localparam logic [W:0] AE_L  = (W+1)'(AE_LVL);

  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;
  logic [W:0]   level;
  logic         overflow;
  logic         underflow;
  logic         full;
  logic         empty;
  logic         wr_ok;
  logic         rd_ok;
  logic         ovf_set;
  logic         udf_set;
  logic         we;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);

  // A write at full is only possible because the same-edge read frees the slot.
  assign wr_ok   = bus.wr & (~full | bus.rd);
  assign rd_ok   = bus.rd & ~empty;
  assign ovf_set = ~bus.flush & bus.wr & ~wr_ok;
  assign udf_set = ~bus.flush & bus.rd & empty & ~bus.wr;
  assign we      = wr_ok & ~bus.flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        if (wr_ok && !rd_ok)      level <= level + 1'b1;
        else if (rd_ok && !wr_ok) level <= level - 1'b1;
      end
      // A new error event beats a coincident clear.
      overflow  <= ovf_set | (overflow  & ~bus.clr_err);
      underflow <= udf_set | (underflow & ~bus.clr_err);
    end
  end

  fifo_regfile #(
    .B (B),
    .W (W)
  ) u_regfile (
    .clk    (clk),
    .we     (we),
    .w_addr (wr_ptr),
    .w_data (bus.w_data),
    .r_addr (rd_ptr),
    .r_data (bus.r_data)
  );

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level >= AF_L);
  assign bus.almost_empty = (level <= AE_L);
  assign bus.level        = level;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Directed bench for fifo_level at default parameters (B=8, W=4, AF=14, AE=2).
module tb_fifo_level;

  localparam int B = 8;
  localparam int W = 4;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [B-1:0] exp_q[$];

  fifo_level_if #(.B(B), .W(W)) bus ();

  fifo_level #(.B(B), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs for one cycle, then sample #1 after the edge
  task automatic cyc(input logic w, input logic r, input logic [B-1:0] d,
                     input logic fl = 1'b0, input logic ce = 1'b0);
    bus.wr      = w;
    bus.rd      = r;
    bus.w_data  = d;
    bus.flush   = fl;
    bus.clr_err = ce;
    @(posedge clk);
    #1;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_ae"},    32'(bus.almost_empty), 1);
    chk({tag, "_full"},  32'(bus.full), 0);
    chk({tag, "_af"},    32'(bus.almost_full), 0);
    chk({tag, "_ovf"},   32'(bus.overflow), 0);
    chk({tag, "_udf"},   32'(bus.underflow), 0);
  endtask

  // pop one word and compare against the scoreboard head
  task automatic pop_check(input string tag);
    logic [B-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(bus.empty), 1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bus.r_data), 32'(e));
    end
    cyc(1'b0, 1'b1, '0);
  endtask

  initial begin
    int lvl;
    int written;
    bit up;
    bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("por");

    // basic write/read order
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 8'h33);
    chk("basic_level", 32'(bus.level), 3);
    chk("basic_empty", 32'(bus.empty), 0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    for (int i = 0; i < 3; i++) pop_check("basic_rd");
    chk("basic_empty_end", 32'(bus.empty), 1);
    chk("basic_udf", 32'(bus.underflow), 0);

    // fill to full, overflow
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      exp_q.push_back(8'(i));
      chk("fill_af", 32'(bus.almost_full), 32'(i + 1 >= 14));
      chk("fill_ae", 32'(bus.almost_empty), 32'(i + 1 <= 2));
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_level", 32'(bus.level), 16);
    chk("pre_ovf", 32'(bus.overflow), 0);
    cyc(1'b1, 1'b0, 8'hEE);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_level", 32'(bus.level), 16);
    cyc(1'b1, 1'b0, 8'hEF, 1'b0, 1'b1);
    chk("ovf_set_beats_clr", 32'(bus.overflow), 1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 0);

    // simultaneous rd/wr at full
    chk("full_head", 32'(bus.r_data), 0);
    void'(exp_q.pop_front());
    cyc(1'b1, 1'b1, 8'hAA);
    exp_q.push_back(8'hAA);
    chk("rw_full_level", 32'(bus.level), 16);
    chk("rw_full_full", 32'(bus.full), 1);
    chk("rw_full_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 16; i++) pop_check("full_drain");
    chk("drain_empty", 32'(bus.empty), 1);

    // simultaneous rd/wr at empty, then underflow
    cyc(1'b1, 1'b1, 8'h5C);
    chk("rw_empty_level", 32'(bus.level), 1);
    chk("rw_empty_udf", 32'(bus.underflow), 0);
    chk("rw_empty_data", 32'(bus.r_data), 32'h5C);
    cyc(1'b0, 1'b1, '0);
    chk("rw_empty_pop", 32'(bus.empty), 1);
    cyc(1'b0, 1'b1, '0);
    chk("udf_set", 32'(bus.underflow), 1);
    chk("udf_level", 32'(bus.level), 0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("udf_clr", 32'(bus.underflow), 0);

    // streaming past wrap, bouncing level between 2 and 14
    lvl = 0; written = 0; up = 1'b1;
    while (written < 40 || lvl > 0) begin
      if (written < 40 && (lvl < 2 || up)) begin
        if (lvl >= 2 && written % 5 == 0) begin
          exp_q.push_back(8'(100 + written));
          chk("wrap_rd", 32'(bus.r_data), 32'(exp_q.pop_front()));
          cyc(1'b1, 1'b1, 8'(100 + written));
        end else begin
          exp_q.push_back(8'(100 + written));
          cyc(1'b1, 1'b0, 8'(100 + written));
          lvl++;
        end
        written++;
        if (lvl == 14) up = 1'b0;
      end else begin
        pop_check("wrap_rd");
        lvl--;
        if (lvl == 2) up = 1'b1;
      end
      chk("wrap_level", 32'(bus.level), 32'(lvl));
      chk("wrap_af", 32'(bus.almost_full), 32'(lvl >= 14));
      chk("wrap_ae", 32'(bus.almost_empty), 32'(lvl <= 2));
    end
    chk("wrap_sb_done", 32'(exp_q.size()), 0);

    // flush at level 7 with a coincident write; error flags survive
    cyc(1'b0, 1'b1, '0);
    chk("pre_flush_udf", 32'(bus.underflow), 1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(i + 8'h30));
    chk("pre_flush_level", 32'(bus.level), 7);
    cyc(1'b1, 1'b0, 8'hF0, 1'b1);
    chk("flush_level", 32'(bus.level), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_udf_kept", 32'(bus.underflow), 1);
    cyc(1'b1, 1'b0, 8'h42);
    chk("post_flush_level", 32'(bus.level), 1);
    chk("post_flush_head", 32'(bus.r_data), 32'h42);

    // reset mid-burst beats every other input
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    reset = 1'b0;
    chk_reset_state("burst_rst");
    cyc(1'b1, 1'b0, 8'h99);
    chk("post_rst_level", 32'(bus.level), 1);
    chk("post_rst_head", 32'(bus.r_data), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
